// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: memory freeze, branch flush, load-use stall, fetch-miss bubble, sticky halt.
// Optional cycle counters (stall_cnt, flush_cnt) are built only when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       exmem_dREN,
    input  logic       exmem_dWEN,
    input  logic       exmem_halt,
    input  logic       exmem_branch,
    input  logic       idex_dREN,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       pc_wen,
    output logic       ifid_wen,
    output logic       idex_wen,
    output logic       exmem_wen,
    output logic       memwb_wen,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic       halt,
    output logic       mem_busy,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t state, next_state;
    logic   mem_req, frozen, load_use;

    assign mem_req  = exmem_dREN | exmem_dWEN;
    assign frozen   = mem_req & ~dhit;
    assign load_use = idex_dREN && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        // Reset holds every enable low even though state is already RUN.
        if (!RST) begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (frozen) begin
                        next_state = MEM_WAIT;
                    end else begin
                        idex_wen   = 1'b1;
                        exmem_wen  = 1'b1;
                        memwb_wen  = 1'b1;
                        next_state = exmem_halt ? HALTED : RUN;
                        if (exmem_branch) begin
                            pc_wen      = 1'b1;
                            ifid_wen    = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                        end else if (load_use) begin
                            idex_flush = 1'b1;
                        end else if (!ihit) begin
                            ifid_wen   = 1'b1;
                            ifid_flush = 1'b1;
                        end else begin
                            pc_wen   = 1'b1;
                            ifid_wen = 1'b1;
                        end
                    end
                end
                HALTED:  next_state = HALTED;
                default: next_state = RUN;
            endcase
        end
    end

    assign halt      = (state == HALTED);
    assign mem_busy  = (state == MEM_WAIT);
    assign fsm_state = state;

`ifdef PIPELINE_CTRL_PERF_EN
    // Only branches raise exmem_flush, so it doubles as the branch-flush event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (state != HALTED) begin
            if (!pc_wen)     stall_cnt <= stall_cnt + 32'd1;
            if (exmem_flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: hazard-rule vector table, multi-cycle freeze/halt/reset sequences, and random no-freeze traffic.
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, exmem_branch, idex_dREN;
    logic [4:0] idex_rd, ifid_rs, ifid_rt;
    logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, mem_busy;
    logic [1:0] fsm_state;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    int unsigned exp_stall, exp_flush;
`endif

    // Output word: pc ifid idex exmem memwb | ifid_f idex_f exmem_f memwb_f | halt mem_busy
    localparam logic [10:0] O_IDLE   = 11'b00000000000;
    localparam logic [10:0] O_NORMAL = 11'b11111000000;
    localparam logic [10:0] O_BRANCH = 11'b11111111000;
    localparam logic [10:0] O_LDUSE  = 11'b00111010000;
    localparam logic [10:0] O_FMISS  = 11'b01111100000;
    localparam logic [10:0] O_BUSY   = 11'b00000000001;
    localparam logic [10:0] O_HALTED = 11'b00000000010;

    logic [10:0] outs;
    assign outs = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, mem_busy};

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_q[$];

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
        .exmem_branch(exmem_branch), .idex_dREN(idex_dREN), .idex_rd(idex_rd),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .mem_busy(mem_busy),
`ifdef PIPELINE_CTRL_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       ihit, dhit, dren, dwen, xhalt, branch, idren;
        logic [4:0] rd, rs, rt;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic ih, dh, dr, dw, xh, br, idr,
                                input logic [4:0] rd, rs, rt, input logic [10:0] e);
        vec_t v;
        v = '{ihit: ih, dhit: dh, dren: dr, dwen: dw, xhalt: xh, branch: br,
              idren: idr, rd: rd, rs: rs, rt: rt, exp: e};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; exmem_dREN = v.dren; exmem_dWEN = v.dwen;
        exmem_halt = v.xhalt; exmem_branch = v.branch; idex_dREN = v.idren;
        idex_rd = v.rd; ifid_rs = v.rs; ifid_rt = v.rt;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; compares at the negedge, returns at next posedge+1.
    task automatic step(input logic [10:0] exp, input string tag);
        logic [10:0] e;
        exp_q.push_back(exp);
        @(negedge CLK);
        e = exp_q.pop_front();
        n_tests++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, outs, e);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        if (!e[10] && !e[1]) exp_stall++;
        if (e[3]) exp_flush++;
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        apply(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, O_NORMAL));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
`ifdef PIPELINE_CTRL_PERF_EN
        exp_stall = 0;
        exp_flush = 0;
`endif
    endtask

    function automatic logic [10:0] ref_run(input logic ih, br, idr, input logic [4:0] rd, rs, rt);
        if (br) return O_BRANCH;
        if (idr && rd != 0 && (rd == rs || rd == rt)) return O_LDUSE;
        if (!ih) return O_FMISS;
        return O_NORMAL;
    endfunction

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_NORMAL);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_FMISS);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 1, 5'd5,  5'd1,  5'd5,  O_LDUSE);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 1, 5'd0,  5'd1,  5'd5,  O_NORMAL);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  O_NORMAL);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 1, 5'd7,  5'd7,  5'd2,  O_LDUSE);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 0, 5'd7,  5'd7,  5'd7,  O_NORMAL);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 5'd9,  5'd9,  5'd3,  O_LDUSE);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 1, 5'd5,  5'd4,  5'd5,  O_BRANCH);
        vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  O_NORMAL);
        vecs[10] = mk(1, 0, 0, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  O_IDLE);
        vecs[11] = mk(1, 1, 0, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  O_BRANCH | O_BUSY);
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 1, 5'd31, 5'd0,  5'd31, O_LDUSE);

        // Reset state with active-looking inputs.
        RST = 1'b1;
        idle_inputs();
        #3;
        check("reset_outs", {21'd0, outs}, {21'd0, O_IDLE});
        check("reset_state", {30'd0, fsm_state}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
`ifdef PIPELINE_CTRL_PERF_EN
        exp_stall = 0;
        exp_flush = 0;
        check("reset_stall_cnt", stall_cnt, 32'd0);
`endif

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            step(vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("table_end_state", {30'd0, fsm_state}, 32'd0);

        // Read miss for three cycles, then hit.
        idle_inputs();
        exmem_dREN = 1'b1;
        step(O_IDLE, "miss_c1");
        step(O_BUSY, "miss_c2");
        step(O_BUSY, "miss_c3");
        dhit = 1'b1;
        step(O_NORMAL | O_BUSY, "miss_hit");
        check("miss_state_run", {30'd0, fsm_state}, 32'd0);
        idle_inputs();
        step(O_NORMAL, "miss_after");

        // Load-use stall lasts one cycle once the hazard clears.
        apply(mk(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, O_LDUSE));
        step(O_LDUSE, "lduse_once");
        idle_inputs();
        step(O_NORMAL, "lduse_release");
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_stall_mid", stall_cnt, exp_stall);
        check("perf_flush_mid", flush_cnt, exp_flush);
`endif

        // Halt behind a pending store.
        idle_inputs();
        exmem_halt = 1'b1;
        exmem_dWEN = 1'b1;
        step(O_IDLE, "halt_frozen");
        dhit = 1'b1;
        step(O_NORMAL | O_BUSY, "halt_advance");
        for (int i = 0; i < 10; i++) begin
            apply(mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), O_HALTED));
            step(O_HALTED, $sformatf("halted%0d", i));
        end
        check("halted_state", {30'd0, fsm_state}, 32'd2);
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_stall_halt", stall_cnt, exp_stall);
        check("perf_flush_halt", flush_cnt, exp_flush);
`endif

        // Reset pulse in the middle of a memory wait.
        do_reset();
        idle_inputs();
        exmem_dREN = 1'b1;
        step(O_IDLE, "rstw_freeze");
        step(O_BUSY, "rstw_wait");
        #2;
        RST = 1'b1;
        #1;
        check("rstw_async_outs", {21'd0, outs}, {21'd0, O_IDLE});
        check("rstw_async_state", {30'd0, fsm_state}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle_inputs();
`ifdef PIPELINE_CTRL_PERF_EN
        exp_stall = 0;
        exp_flush = 0;
        check("rstw_stall_cnt", stall_cnt, 32'd0);
`endif
        step(O_NORMAL, "rstw_release");

        // Random traffic without freezes: memory accesses always hit.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = mk($urandom_range(0, 1), 1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0,
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   O_IDLE);
            v.exp = ref_run(v.ihit, v.branch, v.idren, v.rd, v.rs, v.rt);
            apply(v);
            step(v.exp, $sformatf("rand%0d", i));
        end
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_stall_end", stall_cnt, exp_stall);
        check("perf_flush_end", flush_cnt, exp_flush);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
